// File: rtl/uart_frame_rx.sv
// Frame decoder behind the UART RX FIFO: hunts for SOF/LEN/payload/XOR frames,
// buffers the payload and streams it out over valid/ready only when the checksum matches.
module uart_frame_rx #(
   parameter int unsigned MAX_LEN = 16,
   parameter logic [7:0]  SOF     = 8'h55,
   parameter int unsigned TIMEOUT = 104_167
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_rd_en,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       frame_ok,
   output logic       chk_err,
   output logic       len_err,
   output logic       timeout_err
);

   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int GW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [GW-1:0] GAP_MAX   = GW'(TIMEOUT - 1);
   localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

   typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHK, SEND} state_t;

   state_t        state_q;
   logic [7:0]    mem_q [MAX_LEN];
   logic [LW-1:0] len_q, wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
   logic [7:0]    chk_q;
   logic [GW-1:0] gap_q, gap_d;
   logic          byte_vld_q;
   logic          fetching, gap_expired;

   assign fetching    = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);
   assign fifo_rd_en  = rst_n && (state_q != SEND) && !fifo_empty && !byte_vld_q;
   assign rd_ptr_nxt  = rd_ptr_q + LW'(1);
   assign gap_expired = fetching && (gap_q == GAP_MAX) && !byte_vld_q && !fifo_rd_en;

   // The gap restarts when a read is issued, so it reads zero while that byte is valid.
   always_comb begin
      gap_d = gap_q;
      if (!fetching || fifo_rd_en) begin
         gap_d = '0;
      end else if (gap_q != GAP_MAX) begin
         gap_d = gap_q + GW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == PAYLOAD && byte_vld_q) begin
         mem_q[wr_ptr_q[AW-1:0]] <= fifo_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= HUNT;
         len_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         chk_q       <= '0;
         gap_q       <= '0;
         byte_vld_q  <= 1'b0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         frame_ok    <= 1'b0;
         chk_err     <= 1'b0;
         len_err     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         byte_vld_q  <= fifo_rd_en;
         gap_q       <= gap_d;
         frame_ok    <= 1'b0;
         chk_err     <= 1'b0;
         len_err     <= 1'b0;
         timeout_err <= 1'b0;
         if (gap_expired) begin
            timeout_err <= 1'b1;
            state_q     <= HUNT;
            wr_ptr_q    <= '0;
            gap_q       <= '0;
         end else if (byte_vld_q) begin
            unique case (state_q)
               HUNT: begin
                  if (fifo_data == SOF) begin
                     state_q <= LEN;
                     gap_q   <= '0;
                  end
               end
               LEN: begin
                  gap_q <= '0;
                  if (fifo_data == 8'h00 || fifo_data > MAX_LEN_B) begin
                     len_err <= 1'b1;
                     state_q <= HUNT;
                  end else begin
                     len_q    <= LW'(fifo_data);
                     chk_q    <= fifo_data;
                     wr_ptr_q <= '0;
                     state_q  <= PAYLOAD;
                  end
               end
               PAYLOAD: begin
                  chk_q    <= chk_q ^ fifo_data;
                  wr_ptr_q <= wr_ptr_q + LW'(1);
                  if (wr_ptr_q + LW'(1) == len_q) begin
                     state_q <= CHK;
                     gap_q   <= '0;
                  end
               end
               CHK: begin
                  gap_q <= '0;
                  if (fifo_data == chk_q) begin
                     frame_ok  <= 1'b1;
                     rd_ptr_q  <= '0;
                     out_valid <= 1'b1;
                     out_data  <= mem_q[0];
                     out_last  <= (len_q == LW'(1));
                     state_q   <= SEND;
                  end else begin
                     chk_err <= 1'b1;
                     state_q <= HUNT;
                  end
               end
               default: ;
            endcase
         end else if (state_q == SEND && out_valid && out_ready) begin
            if (out_last) begin
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               state_q   <= HUNT;
            end else begin
               rd_ptr_q <= rd_ptr_nxt;
               out_data <= mem_q[rd_ptr_nxt[AW-1:0]];
               out_last <= (rd_ptr_nxt == len_q - LW'(1));
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: directed frames plus random frame streams, checked against a
// frame parser that walks the byte stream with the SOF/LEN/payload/checksum rules.
module tb_uart_frame_rx;

   localparam int         MAX_LEN    = 16;
   localparam logic [7:0] SOF        = 8'h55;
   localparam int         TB_TIMEOUT = 24;

   logic       clk        = 1'b0;
   logic       rst_n      = 1'b0;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_data  = 8'h00;
   logic       out_ready  = 1'b1;
   logic       fifo_rd_en, out_valid, out_last, frame_ok, chk_err, len_err, timeout_err;
   logic [7:0] out_data;

   uart_frame_rx #(.MAX_LEN(MAX_LEN), .SOF(SOF), .TIMEOUT(TB_TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fifo_empty  (fifo_empty),
      .fifo_data   (fifo_data),
      .fifo_rd_en  (fifo_rd_en),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .frame_ok    (frame_ok),
      .chk_err     (chk_err),
      .len_err     (len_err),
      .timeout_err (timeout_err)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] fifoQ[$];
   logic [7:0] gotData[$];
   logic       gotLast[$];
   int         okCnt, chkCnt, lenCnt, toCnt, rdCnt;
   int         cycle = 0;
   int         lastRdCycle = 0;
   int         toCycle = 0;
   int         readyMode = 0;
   int         readyIdx = 0;

   initial forever #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic clearObs();
      gotData.delete();
      gotLast.delete();
      okCnt  = 0;
      chkCnt = 0;
      lenCnt = 0;
      toCnt  = 0;
      rdCnt  = 0;
   endtask

   // RX FIFO model: a pop requested in one cycle presents its byte during the next cycle.
   // out_ready modes: 0 always high, 1 pattern 1,0,0 repeating, 2 held low, 3 random.
   initial begin
      logic rdSeen;
      forever begin
         @(negedge clk);
         rdSeen = fifo_rd_en;
         @(posedge clk);
         #1;
         if (rdSeen && fifoQ.size() > 0) fifo_data = fifoQ.pop_front();
         fifo_empty = (fifoQ.size() == 0);
         case (readyMode)
            0: out_ready = 1'b1;
            1: begin
               out_ready = (readyIdx % 3 == 0);
               readyIdx++;
            end
            2: out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Observer: counts pops and pulses, records accepted bytes, and checks that a stalled
   // output stays frozen and that no pop happens while a payload is being presented.
   initial begin
      logic       pv, pr, prst, pl;
      logic [7:0] pd;
      pv = 1'b0; pr = 1'b0; prst = 1'b0; pl = 1'b0; pd = 8'h00;
      forever begin
         @(negedge clk);
         cycle++;
         if (fifo_rd_en) begin
            rdCnt++;
            lastRdCycle = cycle;
         end
         if (frame_ok) okCnt++;
         if (chk_err) chkCnt++;
         if (len_err) lenCnt++;
         if (timeout_err) begin
            toCnt++;
            toCycle = cycle;
         end
         if (frame_ok || chk_err || len_err || timeout_err)
            checkOutput("pulse_exclusive",
                        32'(frame_ok) + 32'(chk_err) + 32'(len_err) + 32'(timeout_err), 32'd1);
         if (out_valid) checkOutput("rd_en_during_send", 32'(fifo_rd_en), 32'd0);
         if (pv && !pr && prst) begin
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_data", 32'(out_data), 32'(pd));
            checkOutput("hold_last", 32'(out_last), 32'(pl));
         end
         if (out_valid && out_ready) begin
            gotData.push_back(out_data);
            gotLast.push_back(out_last);
         end
         pv = out_valid; pr = out_ready; prst = rst_n; pd = out_data; pl = out_last;
      end
   end

   // Queue the bytes, then run until the FIFO is drained and the block has been idle long
   // enough for any pending timeout to fire.
   task automatic applyStimulus(input logic [7:0] stream[$]);
      int quiet = 0;
      int spent = 0;
      foreach (stream[i]) fifoQ.push_back(stream[i]);
      while (quiet < TB_TIMEOUT + 10 && spent < 20000) begin
         @(negedge clk);
         spent++;
         if (fifoQ.size() == 0 && !out_valid && !fifo_rd_en) quiet++;
         else quiet = 0;
      end
      checkOutput("drain_budget", 32'(quiet >= TB_TIMEOUT + 10), 32'd1);
   endtask

   task automatic verifyStream(input string tag, input logic [7:0] stream[$]);
      logic [7:0] expData[$];
      logic       expLast[$];
      logic [7:0] x;
      int         expOk, expChk, expLen, expTo, i, n, L, m;
      expOk = 0; expChk = 0; expLen = 0; expTo = 0; i = 0;
      n = stream.size();
      while (i < n) begin
         if (stream[i] != SOF) begin
            i++;
            continue;
         end
         if (i + 1 >= n) begin
            expTo++;
            break;
         end
         L = int'(stream[i+1]);
         if (L == 0 || L > MAX_LEN) begin
            expLen++;
            i += 2;
            continue;
         end
         if (i + 2 + L >= n) begin
            expTo++;
            break;
         end
         x = stream[i+1];
         for (int k = 0; k < L; k++) x ^= stream[i+2+k];
         if (x == stream[i+2+L]) begin
            expOk++;
            for (int k = 0; k < L; k++) begin
               expData.push_back(stream[i+2+k]);
               expLast.push_back(k == L - 1);
            end
         end else begin
            expChk++;
         end
         i += L + 3;
      end
      checkOutput({tag, "_frame_ok"}, okCnt, expOk);
      checkOutput({tag, "_chk_err"}, chkCnt, expChk);
      checkOutput({tag, "_len_err"}, lenCnt, expLen);
      checkOutput({tag, "_timeout_err"}, toCnt, expTo);
      checkOutput({tag, "_rd_pulses"}, rdCnt, n);
      checkOutput({tag, "_out_count"}, gotData.size(), expData.size());
      m = (gotData.size() < expData.size()) ? gotData.size() : expData.size();
      for (int k = 0; k < m; k++) begin
         checkOutput($sformatf("%s_data%0d", tag, k), 32'(gotData[k]), 32'(expData[k]));
         checkOutput($sformatf("%s_last%0d", tag, k), 32'(gotLast[k]), 32'(expLast[k]));
      end
   endtask

   task automatic makeRandomStream(output logic [7:0] s[$]);
      int         nf, kind, L;
      logic [7:0] b, x;
      s = {};
      nf = $urandom_range(2, 5);
      for (int f = 0; f < nf; f++) begin
         kind = $urandom_range(0, 4);
         if (kind <= 2) begin
            L = $urandom_range(1, MAX_LEN);
            x = 8'(L);
            s.push_back(SOF);
            s.push_back(8'(L));
            for (int k = 0; k < L; k++) begin
               b = 8'($urandom);
               s.push_back(b);
               x ^= b;
            end
            if (kind == 2) x ^= 8'($urandom_range(1, 255));
            s.push_back(x);
         end else if (kind == 3) begin
            s.push_back(SOF);
            s.push_back(($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
         end else begin
            for (int k = 0; k < $urandom_range(1, 3); k++) begin
               do b = 8'($urandom); while (b == SOF);
               s.push_back(b);
            end
         end
      end
   endtask

   initial begin
      logic [7:0] s[$];
      int         waited;

      clearObs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data", 32'(out_data), 32'd0);
      checkOutput("rst_out_last", 32'(out_last), 32'd0);
      checkOutput("rst_frame_ok", 32'(frame_ok), 32'd0);
      checkOutput("rst_chk_err", 32'(chk_err), 32'd0);
      checkOutput("rst_len_err", 32'(len_err), 32'd0);
      checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      $display("[TB] good frame");
      clearObs();
      s = {8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      applyStimulus(s);
      verifyStream("good", s);
      checkOutput("good_ok_once", okCnt, 1);
      checkOutput("good_rd_six", rdCnt, 6);
      if (gotData.size() == 3) begin
         checkOutput("good_byte2", 32'(gotData[2]), 32'h33);
         checkOutput("good_last_only_end", {29'd0, gotLast[0], gotLast[1], gotLast[2]}, 32'd1);
      end else begin
         checkOutput("good_size", gotData.size(), 3);
      end

      $display("[TB] garbage then frame");
      clearObs();
      s = {8'h00, 8'h7F, 8'h55, 8'h01, 8'hAA, 8'hAB};
      applyStimulus(s);
      verifyStream("garbage", s);
      if (gotData.size() == 1) checkOutput("garbage_byte", {23'd0, gotLast[0], gotData[0]}, 32'h1AA);
      else checkOutput("garbage_size", gotData.size(), 1);

      $display("[TB] checksum error then good frame");
      clearObs();
      s = {8'h55, 8'h02, 8'h10, 8'h20, 8'h31, 8'h55, 8'h01, 8'h05, 8'h04};
      applyStimulus(s);
      verifyStream("chkerr", s);
      checkOutput("chkerr_once", chkCnt, 1);

      $display("[TB] length errors");
      clearObs();
      s = {8'h55, 8'h00, 8'h55, 8'h11};
      applyStimulus(s);
      verifyStream("lenerr", s);
      checkOutput("lenerr_twice", lenCnt, 2);

      // The 10 byte is popped in cycle R and valid in R+1; the pulse appears TIMEOUT cycles
      // after that byte_vld cycle.
      $display("[TB] inter-byte timeout");
      clearObs();
      s = {8'h55, 8'h02, 8'h10};
      applyStimulus(s);
      verifyStream("timeout", s);
      checkOutput("timeout_latency", toCycle - (lastRdCycle + 1), TB_TIMEOUT);

      $display("[TB] backpressure");
      clearObs();
      readyIdx  = 0;
      readyMode = 1;
      s = {8'h55, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00};
      applyStimulus(s);
      verifyStream("backpressure", s);
      readyMode = 0;

      $display("[TB] reset during send");
      readyMode = 2;
      clearObs();
      s = {8'h55, 8'h02, 8'h77, 8'h88, 8'hFD};
      foreach (s[i]) fifoQ.push_back(s[i]);
      waited = 0;
      while (!out_valid && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("rst_send_reached", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
      clearObs();
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      readyMode = 0;
      @(negedge clk);
      checkOutput("rst_send_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_send_last", 32'(out_last), 32'd0);
      repeat (4) @(negedge clk);
      checkOutput("rst_send_pulses", okCnt + chkCnt + lenCnt + toCnt, 0);
      checkOutput("rst_send_no_output", gotData.size(), 0);
      clearObs();
      s = {8'h55, 8'h01, 8'h42, 8'h43};
      applyStimulus(s);
      verifyStream("after_rst", s);

      $display("[TB] random streams");
      for (int r = 0; r < 8; r++) begin
         readyIdx  = 0;
         readyMode = (r % 2 == 1) ? 3 : 0;
         clearObs();
         makeRandomStream(s);
         applyStimulus(s);
         verifyStream($sformatf("rand%0d", r), s);
      end
      readyMode = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
